// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/datapath signal bundle for the multicycle MIPS controller
interface mips_multicycle_ctrl_if;
  logic       clk_enable;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       branch_taken;
  logic       target_zero;
  logic [2:0] state;
  logic       active;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       target_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wb_src;
  logic       alu_src_imm;
  logic       data_read;
  logic       data_write;
  logic       illegal_instr;

  // controller side
  modport master (
    input  clk_enable, opcode, funct, branch_taken, target_zero,
    output state, active, ir_write, pc_write, pc_src, target_write, reg_write,
           reg_dst, wb_src, alu_src_imm, data_read, data_write, illegal_instr
  );

  // datapath side
  modport slave (
    output clk_enable, opcode, funct, branch_taken, target_zero,
    input  state, active, ir_write, pc_write, pc_src, target_write, reg_write,
           reg_dst, wb_src, alu_src_imm, data_read, data_write, illegal_instr
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM; MIPS_CTRL_DELAY_SLOT_EN enables branch delay slot
module mips_multicycle_ctrl #(
  parameter bit RESET_ACTIVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALTED = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_J, C_JAL, C_JR, C_JALR, C_ILLEGAL
  } class_t;

  state_t state_q, state_d;
  logic   halt_pending_q, halt_pending_d;
  logic   illegal_q, illegal_d;
`ifdef MIPS_CTRL_DELAY_SLOT_EN
  logic   target_pending_q, target_pending_d;
  logic   in_slot_q, in_slot_d;
`endif

  class_t     cls;
  logic       redirect, commit, fin, en;
  logic       ir_write_s, pc_write_s, target_write_s, reg_write_s, data_read_s, data_write_s;
  logic [1:0] pc_src_s;

  // instruction class from the latched IR fields
  always_comb begin
    cls = C_ILLEGAL;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b001000: cls = C_JR;
          6'b001001: cls = C_JALR;
          default:   cls = C_ALU_R;
        endcase
      end
      6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: cls = C_BRANCH;
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      6'b001001, 6'b001010, 6'b001011, 6'b001100,
      6'b001101, 6'b001110, 6'b001111: cls = C_ALU_I;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: cls = C_LOAD;
      6'b101000, 6'b101001, 6'b101011: cls = C_STORE;
      default: cls = C_ILLEGAL;
    endcase
  end

  // sequencing, control-transfer bookkeeping and raw strobe decode
  always_comb begin
    state_d        = state_q;
    halt_pending_d = halt_pending_q;
    illegal_d      = illegal_q;
`ifdef MIPS_CTRL_DELAY_SLOT_EN
    target_pending_d = target_pending_q;
    in_slot_d        = in_slot_q;
`endif
    ir_write_s     = 1'b0;
    pc_write_s     = 1'b0;
    target_write_s = 1'b0;
    reg_write_s    = 1'b0;
    data_read_s    = 1'b0;
    data_write_s   = 1'b0;
    pc_src_s       = 2'd0;
    fin            = 1'b0;
    redirect = (cls inside {C_J, C_JAL, C_JR, C_JALR}) ||
               ((cls == C_BRANCH) && bus.branch_taken);
    commit   = (state_q == S_EX) && redirect;

    case (state_q)
      S_IF: begin
        ir_write_s = 1'b1;
        state_d    = S_ID;
      end
      S_ID: begin
        if (cls == C_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = S_HALTED;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (cls)
          C_LOAD, C_STORE:     state_d = S_MEM;
          C_BRANCH, C_J, C_JR: fin = 1'b1;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls == C_STORE) begin
          data_write_s = 1'b1;
          fin          = 1'b1;
        end else begin
          data_read_s = 1'b1;
          state_d     = S_WB;
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        fin         = 1'b1;
      end
      default: state_d = S_HALTED;
    endcase

`ifdef MIPS_CTRL_DELAY_SLOT_EN
    // a transfer inside the delay slot is ignored: the pending target already owns the PC
    if (commit && !target_pending_q) begin
      target_write_s   = 1'b1;
      target_pending_d = 1'b1;
      if (bus.target_zero) halt_pending_d = 1'b1;
    end
    if (fin) begin
      pc_write_s = 1'b1;
      state_d    = S_IF;
      if (in_slot_q) begin
        pc_src_s         = 2'd2;
        target_pending_d = 1'b0;
        in_slot_d        = 1'b0;
        if (halt_pending_q) state_d = S_HALTED;
      end else if (target_pending_d) begin
        in_slot_d = 1'b1;
      end
    end
`else
    if (commit && bus.target_zero) halt_pending_d = 1'b1;
    if (fin) begin
      pc_write_s = 1'b1;
      pc_src_s   = redirect ? 2'd1 : 2'd0;
      state_d    = halt_pending_d ? S_HALTED : S_IF;
    end
`endif
  end

  // state and flag registers; clk_enable freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RESET_ACTIVE ? S_IF : S_HALTED;
      halt_pending_q   <= 1'b0;
      illegal_q        <= 1'b0;
`ifdef MIPS_CTRL_DELAY_SLOT_EN
      target_pending_q <= 1'b0;
      in_slot_q        <= 1'b0;
`endif
    end else if (bus.clk_enable) begin
      state_q          <= state_d;
      halt_pending_q   <= halt_pending_d;
      illegal_q        <= illegal_d;
`ifdef MIPS_CTRL_DELAY_SLOT_EN
      target_pending_q <= target_pending_d;
      in_slot_q        <= in_slot_d;
`endif
    end
  end

  assign en = bus.clk_enable & ~reset;

  assign bus.state         = state_q;
  assign bus.active        = (state_q != S_HALTED);
  assign bus.illegal_instr = illegal_q;
  assign bus.ir_write      = ir_write_s & en;
  assign bus.pc_write      = pc_write_s & en;
  assign bus.target_write  = target_write_s & en;
  assign bus.reg_write     = reg_write_s & en;
  assign bus.data_read     = data_read_s & en;
  assign bus.data_write    = data_write_s & en;
  assign bus.pc_src        = pc_src_s;
  assign bus.alu_src_imm   = cls inside {C_ALU_I, C_LOAD, C_STORE};
  assign bus.reg_dst       = (cls == C_JAL) ? 2'd2 :
                             (cls inside {C_ALU_R, C_JALR}) ? 2'd1 : 2'd0;
  assign bus.wb_src        = (cls == C_LOAD) ? 2'd1 :
                             (cls inside {C_JAL, C_JALR}) ? 2'd2 : 2'd0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef MIPS_CTRL_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // reference model: instruction-level view of pending target / slot / halt
  bit m_pending, m_slot, m_halt_pend, m_halted, m_illegal;

  // kinds: 0 alu_r 1 alu_i 2 load 3 store 4 branch 5 j 6 jal 7 jr 8 jalr 9 illegal
  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == 0) return (fn == 8) ? 7 : (fn == 9) ? 8 : 0;
    if (op == 1 || (op >= 4 && op <= 7)) return 4;
    if (op == 2) return 5;
    if (op == 3) return 6;
    if (op >= 9 && op <= 15) return 1;
    if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37) return 2;
    if (op == 40 || op == 41 || op == 43) return 3;
    return 9;
  endfunction

  function automatic logic [10:0] observed();
    return {bus.state, bus.active, bus.illegal_instr, bus.ir_write, bus.pc_write,
            bus.target_write, bus.reg_write, bus.data_read, bus.data_write};
  endfunction

  task automatic check_halted(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== {3'd5, 1'b0, m_illegal, 6'b0}) begin
        failures++;
        $display("FAIL halted got=%b exp=%b", observed(), {3'd5, 1'b0, m_illegal, 6'b0});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ir_write, bus.pc_write, bus.target_write, bus.reg_write, bus.data_read, bus.data_write} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=000000",
               {bus.ir_write, bus.pc_write, bus.target_write, bus.reg_write, bus.data_read, bus.data_write});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_pending = 0; m_slot = 0; m_halt_pend = 0; m_halted = 0; m_illegal = 0;
    checks++;
    if ({bus.state, bus.active, bus.illegal_instr} !== {3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL after_reset got=%b exp=00010", {bus.state, bus.active, bus.illegal_instr});
    end
  endtask

  // run one instruction through the DUT, checking every cycle against the model
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit bt, input bit tz,
                           input int stall_at);
    int k;
    logic [2:0] seq[$];
    logic [2:0] s;
    bit redirect, takes, fin;
    logic [10:0] exp_v;
    logic [1:0] exp_src, exp_dst, exp_wb;
    if (m_halted) begin
      check_halted(1);
      return;
    end
    k = kind(op, fn);
    bus.opcode = op; bus.funct = fn; bus.branch_taken = bt; bus.target_zero = tz;
    seq = {3'd0, 3'd1};
    if (k != 9) begin
      seq.push_back(3'd2);
      if (k == 2 || k == 3) seq.push_back(3'd3);
      if (k == 0 || k == 1 || k == 2 || k == 6 || k == 8) seq.push_back(3'd4);
    end
    redirect = (k >= 5 && k <= 8) || (k == 4 && bt);
    takes    = DS && redirect && !m_pending;
    for (int i = 0; i < seq.size(); i++) begin
      s   = seq[i];
      fin = (k != 9) && (i == seq.size() - 1);
      if (i == stall_at) begin
        bus.clk_enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checks++;
          if (observed() !== {s, 1'b1, m_illegal, 6'b0}) begin
            failures++;
            $display("FAIL stall cyc=%0d got=%b exp=%b", c, observed(), {s, 1'b1, m_illegal, 6'b0});
          end
          @(posedge clk); #1;
        end
        bus.clk_enable = 1'b1;
      end
      exp_v = {s, 1'b1, m_illegal, (s == 3'd0), fin, (takes && s == 3'd2), (s == 3'd4),
               (s == 3'd3 && k == 2), (s == 3'd3 && k == 3)};
      @(negedge clk);
      checks++;
      if (observed() !== exp_v) begin
        failures++;
        $display("FAIL step op=%0d fn=%0d idx=%0d got=%b exp=%b", op, fn, i, observed(), exp_v);
      end
      if (fin) begin
        exp_src = DS ? (m_slot ? 2'd2 : 2'd0) : (redirect ? 2'd1 : 2'd0);
        checks++;
        if (bus.pc_src !== exp_src) begin
          failures++;
          $display("FAIL pc_src op=%0d got=%0d exp=%0d", op, bus.pc_src, exp_src);
        end
      end
      if (s == 3'd2) begin
        checks++;
        if (bus.alu_src_imm !== (k == 1 || k == 2 || k == 3)) begin
          failures++;
          $display("FAIL alu_src_imm op=%0d got=%b", op, bus.alu_src_imm);
        end
      end
      if (s == 3'd4) begin
        exp_dst = (k == 6) ? 2'd2 : (k == 0 || k == 8) ? 2'd1 : 2'd0;
        exp_wb  = (k == 2) ? 2'd1 : (k == 6 || k == 8) ? 2'd2 : 2'd0;
        checks++;
        if ({bus.reg_dst, bus.wb_src} !== {exp_dst, exp_wb}) begin
          failures++;
          $display("FAIL wb_selects op=%0d got=%b exp=%b", op, {bus.reg_dst, bus.wb_src}, {exp_dst, exp_wb});
        end
      end
      @(posedge clk); #1;
    end
    if (k == 9) begin
      m_illegal = 1; m_halted = 1;
    end else if (DS) begin
      if (m_slot) begin
        m_slot = 0; m_pending = 0;
        if (m_halt_pend) m_halted = 1;
      end else if (takes) begin
        m_pending = 1; m_slot = 1;
        if (tz) m_halt_pend = 1;
      end
    end else if (redirect && tz) begin
      m_halted = 1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_addiu();
    run_instr(6'b001001, 6'd0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_load_store();
    run_instr(6'b100011, 6'd0, 1'b0, 1'b0, -1);
    run_instr(6'b101011, 6'd0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'd0, 1'b1, 1'b0, -1);
    run_instr(6'b001001, 6'd0, 1'b0, 1'b0, -1);
    run_instr(6'b000100, 6'd0, 1'b0, 1'b0, -1);
    run_instr(6'b001001, 6'd0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_jr_halt();
    run_instr(6'b000000, 6'b001000, 1'b0, 1'b1, -1);
    run_instr(6'b001001, 6'd0, 1'b0, 1'b0, -1);
    checks++;
    if (!m_halted) begin
      failures++;
      $display("FAIL jr_halt model did not halt");
    end
    check_halted(2);
    apply_reset();
  endtask

  task automatic test_stall();
    run_instr(6'b101011, 6'd0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 6'd0, 1'b0, 1'b0, -1);
    check_halted(3);
    apply_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [25];
    logic [5:0] op, fn;
    ops = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11,
            6'd12, 6'd13, 6'd14, 6'd15, 6'd32, 6'd33, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43};
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 24)];
      if ($urandom_range(0, 39) == 0) op = 6'd8;
      fn = 6'($urandom_range(0, 63));
      if (op == 0 && $urandom_range(0, 2) == 0) fn = 6'($urandom_range(8, 9));
      run_instr(op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), -1);
      if (m_halted) begin
        check_halted(2);
        apply_reset();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.clk_enable = 1'b1;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.branch_taken = 1'b0; bus.target_zero = 1'b0;
    m_pending = 0; m_slot = 0; m_halt_pend = 0; m_halted = 0; m_illegal = 0;
    test_reset();
    test_addiu();
    test_load_store();
    test_branch();
    test_jr_halt();
    test_stall();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
